// File: rtl/execute_cc_unit.sv
// Y-86 execute back end: ZF/SF/OF register, jXX/cmov condition, E->M register (1-cycle latency;
// m_stall holds M and blocks CC, m_bubble loads NOP). Optional OF tracking under `ALU_OVERFLOW_EN.
module execute_cc_unit #(
  parameter logic [3:0] RNONE     = 4'hF,
  parameter logic [3:0] NOP_ICODE = 4'h1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        e_valid,
  input  logic [3:0]  e_icode,
  input  logic [3:0]  e_ifun,
  input  logic [63:0] e_valE,
  input  logic        e_alu_ovf,
  input  logic [63:0] e_valA,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  e_dstM,
  input  logic        exc_block,
  input  logic        m_stall,
  input  logic        m_bubble,
  output logic        e_cnd,
  output logic [3:0]  e_dstE_eff,
  output logic        M_valid,
  output logic        M_cnd,
  output logic [3:0]  M_icode,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
  output logic        cc_zf,
  output logic        cc_sf,
  output logic        cc_of
);

  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;

  typedef struct packed {
    logic        valid;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } meta_t;

  localparam meta_t M_BUBBLE = '{
    valid: 1'b0, icode: NOP_ICODE, cnd: 1'b0,
    valE: 64'h0, valA: 64'h0, dstE: RNONE, dstM: RNONE
  };

  logic  zf_q, zf_d;
  logic  sf_q, sf_d;
  logic  of_cur;
  logic  cc_we;
  logic  cond;
  logic  x_flag;
  meta_t m_q, m_d;

  // Condition from the flags held at the start of the cycle (pre-update).
  always_comb begin
    x_flag = sf_q ^ of_cur;
    cond   = 1'b0;
    case (e_ifun)
      4'd0:    cond = 1'b1;
      4'd1:    cond = x_flag | zf_q;
      4'd2:    cond = x_flag;
      4'd3:    cond = zf_q;
      4'd4:    cond = ~zf_q;
      4'd5:    cond = ~x_flag;
      4'd6:    cond = ~x_flag & ~zf_q;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    e_cnd      = ((e_icode == I_CMOVXX) || (e_icode == I_JXX)) ? cond : 1'b0;
    e_dstE_eff = ((e_icode == I_CMOVXX) && !cond) ? RNONE : e_dstE;
  end

  assign cc_we = e_valid & (e_icode == I_OPQ) & ~exc_block & ~m_stall;

  always_comb begin
    zf_d = zf_q;
    sf_d = sf_q;
    if (cc_we) begin
      zf_d = (e_valE == 64'h0);
      sf_d = e_valE[63];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zf_q <= 1'b1;
      sf_q <= 1'b0;
    end else begin
      zf_q <= zf_d;
      sf_q <= sf_d;
    end
  end

`ifdef ALU_OVERFLOW_EN
  logic of_q, of_d;

  // Only add/sub produce a meaningful signed overflow; logic ops clear OF.
  always_comb begin
    of_d = of_q;
    if (cc_we) begin
      of_d = ((e_ifun == 4'd0) || (e_ifun == 4'd1)) ? e_alu_ovf : 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      of_q <= 1'b0;
    end else begin
      of_q <= of_d;
    end
  end

  assign of_cur = of_q;
`else
  logic unused_alu_ovf;

  assign unused_alu_ovf = e_alu_ovf;
  assign of_cur         = 1'b0;
`endif

  // Bubble beats stall; an empty E stage is loaded as a bubble.
  always_comb begin
    m_d = m_q;
    if (m_bubble) begin
      m_d = M_BUBBLE;
    end else if (!m_stall) begin
      if (e_valid) begin
        m_d.valid = 1'b1;
        m_d.icode = e_icode;
        m_d.cnd   = e_cnd;
        m_d.valE  = e_valE;
        m_d.valA  = e_valA;
        m_d.dstE  = e_dstE_eff;
        m_d.dstM  = e_dstM;
      end else begin
        m_d = M_BUBBLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q <= M_BUBBLE;
    end else begin
      m_q <= m_d;
    end
  end

  always_comb begin
    M_valid = m_q.valid;
    M_icode = m_q.icode;
    M_cnd   = m_q.cnd;
    M_valE  = m_q.valE;
    M_valA  = m_q.valA;
    M_dstE  = m_q.dstE;
    M_dstM  = m_q.dstM;
    cc_zf   = zf_q;
    cc_sf   = sf_q;
    cc_of   = of_cur;
  end

endmodule

// File: tb/tb_execute_cc_unit.sv
// Bench for execute_cc_unit: directed scenarios plus randomized traffic against a flag-level model.
module tb_execute_cc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        e_valid;
  logic [3:0]  e_icode;
  logic [3:0]  e_ifun;
  logic [63:0] e_valE;
  logic        e_alu_ovf;
  logic [63:0] e_valA;
  logic [3:0]  e_dstE;
  logic [3:0]  e_dstM;
  logic        exc_block;
  logic        m_stall;
  logic        m_bubble;
  logic        e_cnd;
  logic [3:0]  e_dstE_eff;
  logic        M_valid;
  logic        M_cnd;
  logic [3:0]  M_icode;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic        cc_zf;
  logic        cc_sf;
  logic        cc_of;

  int errors = 0;
  int checks = 0;

  execute_cc_unit dut (
    .clk(clk), .rst(rst), .e_valid(e_valid), .e_icode(e_icode), .e_ifun(e_ifun),
    .e_valE(e_valE), .e_alu_ovf(e_alu_ovf), .e_valA(e_valA), .e_dstE(e_dstE),
    .e_dstM(e_dstM), .exc_block(exc_block), .m_stall(m_stall), .m_bubble(m_bubble),
    .e_cnd(e_cnd), .e_dstE_eff(e_dstE_eff), .M_valid(M_valid), .M_cnd(M_cnd),
    .M_icode(M_icode), .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE),
    .M_dstM(M_dstM), .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
  );

  always #5 clk = ~clk;

  // Reference model: flags and the expected contents of the M register.
  logic        m_zf, m_sf, m_of;
  logic        x_valid, x_cnd;
  logic [3:0]  x_icode, x_dstE, x_dstM;
  logic [63:0] x_valE, x_valA;

  function automatic logic model_cond(input logic [3:0] ifun);
    logic lt;
    lt = m_sf ^ m_of;            // "signed result below zero"
    case (ifun)
      4'd0: return 1'b1;
      4'd1: return lt || m_zf;
      4'd2: return lt;
      4'd3: return m_zf;
      4'd4: return !m_zf;
      4'd5: return !lt;
      4'd6: return !lt && !m_zf;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic model_cnd();
    if (e_icode == 4'd2 || e_icode == 4'd7) return model_cond(e_ifun);
    return 1'b0;
  endfunction

  function automatic logic [3:0] model_dste();
    if (e_icode == 4'd2 && !model_cond(e_ifun)) return 4'hF;
    return e_dstE;
  endfunction

  task automatic model_bubble();
    x_valid = 0; x_icode = 4'h1; x_cnd = 0; x_valE = 0; x_valA = 0; x_dstE = 4'hF; x_dstM = 4'hF;
  endtask

  task automatic model_next();
    logic       c;
    logic [3:0] d;
    c = model_cnd();
    d = model_dste();
    if (rst) begin
      m_zf = 1; m_sf = 0; m_of = 0;
      model_bubble();
    end else begin
      if (e_valid && e_icode == 4'd6 && !exc_block && !m_stall) begin
        m_zf = (e_valE == 64'h0);
        m_sf = e_valE[63];
`ifdef ALU_OVERFLOW_EN
        m_of = (e_ifun == 4'd0 || e_ifun == 4'd1) ? e_alu_ovf : 1'b0;
`endif
      end
      if (m_bubble) model_bubble();
      else if (!m_stall) begin
        if (e_valid) begin
          x_valid = 1; x_icode = e_icode; x_cnd = c; x_valE = e_valE;
          x_valA = e_valA; x_dstE = d; x_dstM = e_dstM;
        end else model_bubble();
      end
    end
  endtask

  task automatic clk_step();
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] ve, input logic ov, input logic [3:0] de);
    e_valid = v; e_icode = ic; e_ifun = fn; e_valE = ve; e_alu_ovf = ov;
    e_valA = {$urandom, $urandom}; e_dstE = de; e_dstM = 4'($urandom_range(0, 15));
  endtask

  task automatic test_reset();
    rst = 1; m_stall = 1; m_bubble = 0; exc_block = 1;
    drive(1, 4'd6, 4'd0, 64'h1234, 1, 4'd5);
    clk_step();
    checks++; if (cc_zf !== 1'b1) begin errors++; $display("FAIL reset_zf got=%b exp=1", cc_zf); end
    checks++; if (cc_sf !== 1'b0) begin errors++; $display("FAIL reset_sf got=%b exp=0", cc_sf); end
    checks++; if (cc_of !== 1'b0) begin errors++; $display("FAIL reset_of got=%b exp=0", cc_of); end
    checks++; if (M_icode !== 4'h1) begin errors++; $display("FAIL reset_icode got=%h exp=1", M_icode); end
    checks++; if (M_dstE !== 4'hF || M_dstM !== 4'hF) begin errors++; $display("FAIL reset_dst got=%h/%h exp=F/F", M_dstE, M_dstM); end
    checks++; if (M_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", M_valid); end
    rst = 0; m_stall = 0; exc_block = 0;
  endtask

  task automatic test_overflow_flags();
    logic exp_of, exp_l, exp_ge;
`ifdef ALU_OVERFLOW_EN
    exp_of = 1; exp_l = 0; exp_ge = 1;
`else
    exp_of = 0; exp_l = 1; exp_ge = 0;
`endif
    drive(1, 4'd6, 4'd0, 64'h8000_0000_0000_0000, 1, 4'd1);
    clk_step();
    checks++; if ({cc_zf, cc_sf, cc_of} !== {1'b0, 1'b1, exp_of}) begin errors++; $display("FAIL ovf_cc got=%b%b%b exp=01%b", cc_zf, cc_sf, cc_of, exp_of); end
    checks++; if (M_valE !== 64'h8000_0000_0000_0000 || M_icode !== 4'd6) begin errors++; $display("FAIL ovf_mload got=%h/%h", M_valE, M_icode); end
    drive(1, 4'd7, 4'd2, 64'h0, 0, 4'hF);
    #2;
    checks++; if (e_cnd !== exp_l) begin errors++; $display("FAIL jl_cnd got=%b exp=%b", e_cnd, exp_l); end
    clk_step();
    checks++; if (M_cnd !== exp_l) begin errors++; $display("FAIL jl_mcnd got=%b exp=%b", M_cnd, exp_l); end
    drive(1, 4'd7, 4'd5, 64'h0, 0, 4'hF);
    #2;
    checks++; if (e_cnd !== exp_ge) begin errors++; $display("FAIL jge_cnd got=%b exp=%b", e_cnd, exp_ge); end
    clk_step();
  endtask

  task automatic test_cmov();
    drive(1, 4'd6, 4'd1, 64'h0, 0, 4'd2);
    clk_step();
    drive(1, 4'd2, 4'd4, 64'h55, 0, 4'd3);
    #2;
    checks++; if (e_cnd !== 1'b0 || e_dstE_eff !== 4'hF) begin errors++; $display("FAIL cmovne_comb got=%b/%h exp=0/F", e_cnd, e_dstE_eff); end
    clk_step();
    checks++; if (M_dstE !== 4'hF || M_cnd !== 1'b0) begin errors++; $display("FAIL cmovne_m got=%h/%b exp=F/0", M_dstE, M_cnd); end
    drive(1, 4'd2, 4'd3, 64'h55, 0, 4'd3);
    #2;
    checks++; if (e_dstE_eff !== 4'd3) begin errors++; $display("FAIL cmove_comb got=%h exp=3", e_dstE_eff); end
    clk_step();
    checks++; if (M_dstE !== 4'd3 || M_cnd !== 1'b1) begin errors++; $display("FAIL cmove_m got=%h/%b exp=3/1", M_dstE, M_cnd); end
  endtask

  task automatic test_exc_block();
    drive(1, 4'd6, 4'd2, 64'hF000_0000_0000_0001, 0, 4'd4);
    clk_step();
    exc_block = 1;
    drive(1, 4'd6, 4'd0, 64'h0, 0, 4'd4);
    clk_step();
    exc_block = 0;
    checks++; if (cc_zf !== 1'b0 || cc_sf !== 1'b1) begin errors++; $display("FAIL exc_cc got=%b%b exp=01", cc_zf, cc_sf); end
    checks++; if (M_valid !== 1'b1 || M_valE !== 64'h0 || M_dstE !== 4'd4) begin errors++; $display("FAIL exc_mload got=%b/%h/%h exp=1/0/4", M_valid, M_valE, M_dstE); end
  endtask

  task automatic test_stall();
    logic [63:0] held_valE;
    logic [3:0]  held_dstM;
    drive(1, 4'd4, 4'd0, 64'hCAFE_F00D, 0, 4'd7);
    clk_step();
    held_valE = 64'hCAFE_F00D;
    held_dstM = x_dstM;
    m_stall = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'd6, 4'd0, 64'h0, 1, 4'(i));
      clk_step();
      checks++; if (M_valE !== held_valE || M_dstM !== held_dstM || M_icode !== 4'd4) begin errors++; $display("FAIL stall_hold%0d got=%h/%h/%h", i, M_valE, M_dstM, M_icode); end
      checks++; if (cc_zf !== 1'b0 || cc_sf !== 1'b1) begin errors++; $display("FAIL stall_cc%0d got=%b%b exp=01", i, cc_zf, cc_sf); end
    end
    m_stall = 0;
    drive(1, 4'd5, 4'd0, 64'h77, 0, 4'd9);
    clk_step();
    checks++; if (M_valE !== 64'h77 || M_icode !== 4'd5 || M_dstE !== 4'd9 || M_valA !== x_valA) begin errors++; $display("FAIL stall_release got=%h/%h/%h", M_valE, M_icode, M_dstE); end
  endtask

  task automatic test_bubble_stall();
    m_bubble = 1; m_stall = 1;
    drive(1, 4'd6, 4'd0, 64'h0, 0, 4'd2);
    clk_step();
    m_bubble = 0; m_stall = 0;
    checks++; if (M_valid !== 1'b0 || M_icode !== 4'h1 || M_dstE !== 4'hF || M_valE !== 64'h0) begin errors++; $display("FAIL bubble_m got=%b/%h/%h/%h", M_valid, M_icode, M_dstE, M_valE); end
    checks++; if (cc_zf !== 1'b0 || cc_sf !== 1'b1) begin errors++; $display("FAIL bubble_cc got=%b%b exp=01", cc_zf, cc_sf); end
  endtask

  task automatic test_random();
    logic [3:0]  ic;
    logic [63:0] ve;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 4))
        0: ic = 4'd2;
        1: ic = 4'd7;
        2, 3: ic = 4'd6;
        default: ic = 4'($urandom_range(0, 15));
      endcase
      case ($urandom_range(0, 2))
        0: ve = 64'h0;
        1: ve = {1'b1, 63'($urandom)};
        default: ve = {$urandom, $urandom};
      endcase
      drive($urandom_range(0, 5) != 0, ic, 4'($urandom_range(0, 15)), ve, 1'($urandom), 4'($urandom_range(0, 15)));
      rst       = ($urandom_range(0, 39) == 0);
      m_stall   = ($urandom_range(0, 4) == 0);
      m_bubble  = ($urandom_range(0, 7) == 0);
      exc_block = ($urandom_range(0, 5) == 0);
      #2;
      checks++; if (e_cnd !== model_cnd() || e_dstE_eff !== model_dste()) begin errors++; $display("FAIL rnd_comb n=%0d got=%b/%h exp=%b/%h", n, e_cnd, e_dstE_eff, model_cnd(), model_dste()); end
      clk_step();
      checks++; if ({cc_zf, cc_sf, cc_of} !== {m_zf, m_sf, m_of}) begin errors++; $display("FAIL rnd_cc n=%0d got=%b%b%b exp=%b%b%b", n, cc_zf, cc_sf, cc_of, m_zf, m_sf, m_of); end
      checks++; if ({M_valid, M_icode, M_cnd, M_dstE, M_dstM} !== {x_valid, x_icode, x_cnd, x_dstE, x_dstM}) begin errors++; $display("FAIL rnd_mctl n=%0d got=%b/%h/%b/%h/%h exp=%b/%h/%b/%h/%h", n, M_valid, M_icode, M_cnd, M_dstE, M_dstM, x_valid, x_icode, x_cnd, x_dstE, x_dstM); end
      checks++; if (M_valE !== x_valE || M_valA !== x_valA) begin errors++; $display("FAIL rnd_mdat n=%0d got=%h/%h exp=%h/%h", n, M_valE, M_valA, x_valE, x_valA); end
    end
    rst = 0; m_stall = 0; m_bubble = 0; exc_block = 0;
  endtask

  initial begin
    m_zf = 1; m_sf = 0; m_of = 0;
    model_bubble();
    test_reset();
    test_overflow_flags();
    test_cmov();
    test_exc_block();
    test_stall();
    test_bubble_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
